serial_subtractor: RTL and testbench

//  Bit-serial N-bit subtractor built around a single full-subtractor cell
//  (diff = a^b^c, borrow = ~a&b | ~(a^b)&c) plus a registered borrow.

---
 rtl/serial_subtractor.sv | 76 +++++++
 tb/tb_serial_subtractor.sv | 137 +++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor, one full-subtractor cell, LSB first
// Ports: clk/rst (async active-high) | start, a, b, bin: operation request and operands
//        busy: run in progress | done: one-cycle result pulse | diff, bout: result and final borrow
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, a_d, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             brw_q, bout_q, busy_q, done_q, d, br;
  assign d  = a_q[0] ^ b_q[0] ^ brw_q;
  assign br = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
  // the consumed minuend bit leaves a_q as the difference bit enters at the top,
  // so a_q doubles as the partial-result register
  assign a_d = {d, a_q[WIDTH-1:1]};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          a_q   <= a_d;
          b_q   <= b_q >> 1;
          brw_q <= br;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            diff_q  <= a_d;
            bout_q  <= br;
          end
        end
        default: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            brw_q   <= bin;
            cnt_q   <= '0;
            state_q <= RUN;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed checks of serial_subtractor at WIDTH=8 plus exhaustive WIDTH=3
module tb_serial_subtractor;
  logic       clk = 1'b0, rst = 1'b1;
  logic       start8 = 1'b0, bin8 = 1'b0, busy8, done8, bout8;
  logic [7:0] a8 = '0, b8 = '0, diff8;
  logic       start3 = 1'b0, bin3 = 1'b0, busy3, done3, bout3;
  logic [2:0] a3 = '0, b3 = '0, diff3;
  int         tests = 0, fails = 0;
  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );
  serial_subtractor #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .bin(bin3),
    .busy(busy3), .done(done3), .diff(diff3), .bout(bout3)
  );
  always #5 clk = ~clk;
  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_done8(output int n);
    n = 0;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic wait_done3(output int n);
    n = 0;
    while (!done3 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin,
                      input logic [7:0] ed, input logic eb, input string tag);
    int n, bc;
    a8 = ta; b8 = tb_; bin8 = tbin; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; n = 0; bc = 0;
    while (!done8 && n < 40) begin
      if (busy8) bc++;
      @(negedge clk);
      n++;
    end
    chk(32'(n), 32'd8, {tag, "_latency"});
    chk(32'(bc), 32'd8, {tag, "_busy_cycles"});
    chk(32'(diff8), 32'(ed), {tag, "_diff"});
    chk(32'(bout8), 32'(eb), {tag, "_bout"});
    @(negedge clk);
    chk(32'(done8), 32'd0, {tag, "_done_one_cycle"});
  endtask
  initial begin
    int n;
    logic [3:0] t;
    @(negedge clk);
    chk(32'({busy8, done8, bout8}), 32'd0, "reset_flags");
    chk(32'(diff8), 32'd0, "reset_diff");
    rst = 1'b0;
    @(negedge clk);
    run8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, "t1");
    run8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, "t2a");
    run8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, "t2b");
    a8 = 8'h80; b8 = 8'h7F; bin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk(32'(diff8), 32'hFF, "t3_diff_held_in_run");
    chk(32'(bout8), 32'd1, "t3_bout_held_in_run");
    wait_done8(n);
    chk(32'(n), 32'd5, "t3_latency");
    chk(32'(diff8), 32'h00, "t3_diff");
    chk(32'(bout8), 32'd0, "t3_bout");
    @(negedge clk);
    chk(32'(done8), 32'd0, "t3_done_one_cycle");
    a8 = 8'hC8; b8 = 8'h64; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    a8 = 8'h01; b8 = 8'h02; bin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(n);
    chk(32'(n), 32'd4, "t4_latency");
    chk(32'(diff8), 32'h64, "t4_diff");
    chk(32'(bout8), 32'd0, "t4_bout");
    repeat (2) @(negedge clk);
    chk(32'({busy8, done8}), 32'd0, "t4_no_second_run");
    a8 = 8'hFF; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    chk(32'(busy8), 32'd1, "t5_busy_before_rst");
    rst = 1'b1;
    #1;
    chk(32'({busy8, done8, bout8}), 32'd0, "t5_rst_flags");
    chk(32'(diff8), 32'd0, "t5_rst_diff");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run8(8'h33, 8'h44, 1'b1, 8'hEE, 1'b1, "t5_after");
    a8 = 8'h10; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    wait_done8(n);
    chk(32'(n), 32'd8, "t6_first_latency");
    chk(32'(diff8), 32'h0D, "t6_first_diff");
    chk(32'(bout8), 32'd0, "t6_first_bout");
    a8 = 8'h07; b8 = 8'h09;
    @(negedge clk);
    chk(32'({busy8, done8}), 32'b10, "t6_back_to_back");
    start8 = 1'b0;
    wait_done8(n);
    chk(32'(n), 32'd8, "t6_second_latency");
    chk(32'(diff8), 32'hFE, "t6_second_diff");
    chk(32'(bout8), 32'd1, "t6_second_bout");
    @(negedge clk);
    for (int i = 0; i < 128; i++) begin
      logic [6:0] v;
      v = 7'(i);
      a3 = v[6:4]; b3 = v[3:1]; bin3 = v[0]; start3 = 1'b1;
      t = {1'b0, v[6:4]} - {1'b0, v[3:1]} - {3'b0, v[0]};
      @(negedge clk);
      start3 = 1'b0;
      wait_done3(n);
      chk(32'(n), 32'd3, $sformatf("w3_latency_%0d", i));
      chk(32'(diff3), 32'(t[2:0]), $sformatf("w3_diff_%0d", i));
      chk(32'(bout3), 32'(t[3]), $sformatf("w3_bout_%0d", i));
      @(negedge clk);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
